// File: rtl/fft_reorder.sv
// Reorders bit-reversed FFT output into natural bin order.
// Two ping-pong banks: one fills in bit-reversed address order while the other drains sequentially.
module fft_reorder #(
    parameter int WIDTH  = 16,
    parameter int N_LOG2 = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              di_en,
    input  logic [WIDTH-1:0]  di_re,
    input  logic [WIDTH-1:0]  di_im,
    output logic              do_en,
    output logic [WIDTH-1:0]  do_re,
    output logic [WIDTH-1:0]  do_im,
    output logic [N_LOG2-1:0] do_idx,
    output logic              overflow
);
    localparam int N = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] LAST = '1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_READ = 1'b1;

    logic [2*WIDTH-1:0] mem [2][N];

    logic [N_LOG2-1:0] wcnt;
    logic [N_LOG2-1:0] rcnt;
    logic              wbank;
    logic              rbank;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic [1:0]        freeing;
    logic [1:0]        wr_block;
    logic [0:0]        state;
    logic              rd_last;
    logic              wr_ok;
    logic [2*WIDTH-1:0] rd_data;

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
        logic [N_LOG2-1:0] r;
        r = '0;
        for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
        return r;
    endfunction

    assign rd_last = (state == S_READ) && (rcnt == LAST);

    always_comb begin
        freeing = '0;
        if (rd_last) freeing[rbank] = 1'b1;
    end

    // A bank whose last entry is being read this cycle is already free for
    // entry 0 of the next frame; this keeps gapless streaming drop-free.
    assign wr_block = full & ~freeing;
    assign wr_ok    = di_en && !wr_block[wbank];
    assign rd_data  = mem[rbank][rcnt];

    always_comb begin
        full_nxt = full;
        if (rd_last) full_nxt[rbank] = 1'b0;
        if (wr_ok && (wcnt == LAST)) full_nxt[wbank] = 1'b1;
    end

    // Buffer storage carries no reset; validity is tracked by the full flags.
    always_ff @(posedge clock) begin
        if (wr_ok) mem[wbank][bitrev(wcnt)] <= {di_re, di_im};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wcnt     <= '0;
            wbank    <= 1'b0;
            full     <= '0;
            overflow <= 1'b0;
        end else begin
            full <= full_nxt;
            if (di_en) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == LAST) wbank <= ~wbank;
                if (!wr_ok) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            rcnt   <= '0;
            rbank  <= 1'b0;
            do_en  <= 1'b0;
            do_re  <= '0;
            do_im  <= '0;
            do_idx <= '0;
        end else begin
            do_en  <= 1'b0;
            do_re  <= '0;
            do_im  <= '0;
            do_idx <= '0;
            case (state)
                S_IDLE: begin
                    rcnt <= '0;
                    if (full[rbank]) begin
                        state <= S_READ;
                    end else if (full[~rbank]) begin
                        rbank <= ~rbank;
                        state <= S_READ;
                    end
                end
                default: begin
                    do_en          <= 1'b1;
                    {do_re, do_im} <= rd_data;
                    do_idx         <= rcnt;
                    rcnt           <= rcnt + 1'b1;
                    // Chain straight into the other bank when it is already waiting.
                    if (rcnt == LAST) begin
                        rbank <= ~rbank;
                        if (!full[~rbank]) state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_reorder.sv
// Scoreboard bench for fft_reorder: ramp, gapped, streaming, reset and overflow cases.
module tb_fft_reorder;
    localparam int WIDTH  = 16;
    localparam int N_LOG2 = 6;
    localparam int N      = 64;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              di_en = 1'b0;
    logic [WIDTH-1:0]  di_re = '0;
    logic [WIDTH-1:0]  di_im = '0;
    logic              do_en;
    logic [WIDTH-1:0]  do_re;
    logic [WIDTH-1:0]  do_im;
    logic [N_LOG2-1:0] do_idx;
    logic              overflow;

    fft_reorder #(.WIDTH(WIDTH), .N_LOG2(N_LOG2)) dut (
        .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
        .do_en(do_en), .do_re(do_re), .do_im(do_im), .do_idx(do_idx), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct { int idx; int re; int im; } exp_t;
    exp_t exp_q[$];
    exp_t tbl[5];

    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    int   first_rise = 0;
    int   run = 0;
    int   last_run = 0;
    int   t_last = 0;
    logic prev_en = 1'b0;
    logic [WIDTH-1:0] cap_re [N];
    logic [WIDTH-1:0] cap_im [N];

    function automatic int brev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < N_LOG2; i++) if (v[i]) r = r | (1 << (N_LOG2 - 1 - i));
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Same-bank last-address write/read collision must never happen.
    initial forever begin
        @(posedge clock);
        if (reset && dut.state == 1'b1 && dut.rcnt == 6'd63 && di_en &&
            dut.wcnt == 6'd63 && dut.wbank == dut.rbank) begin
            err_cnt++;
            $display("FAIL last_addr_collision at cycle %0d", cyc);
        end
    end

    initial forever begin
        @(negedge clock);
        if (do_en) begin
            exp_t e;
            if (!prev_en) begin
                first_rise = cyc;
                run = 0;
            end
            run++;
            cap_re[do_idx] = do_re;
            cap_im[do_idx] = do_im;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("do_idx", longint'(do_idx), e.idx);
                chk("do_re", longint'($signed(do_re)), e.re);
                chk("do_im", longint'($signed(do_im)), e.im);
            end
        end else begin
            if (prev_en) last_run = run;
            chk("idle_zero", longint'({do_re, do_im, do_idx}), 0);
        end
        prev_en = do_en;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send(input int base, input bit gapped, input bit push, input int cnt);
        if (push) begin
            for (int k = 0; k < N; k++) begin
                exp_t e;
                e.idx = k;
                e.re  = base + brev(k);
                e.im  = -(base + brev(k));
                exp_q.push_back(e);
            end
        end
        for (int p = 0; p < cnt; p++) begin
            @(negedge clock);
            di_en = 1'b1;
            di_re = 16'(base + p);
            di_im = 16'(-(base + p));
            if (p == cnt - 1) t_last = cyc + 1;
            if (gapped && p != cnt - 1) begin
                @(negedge clock);
                di_en = 1'b0;
            end
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clock);
            di_en = 1'b0;
            if (exp_q.size() == 0 && !do_en) done = 1'b1;
        end
        chk("drain_timeout", done, 1);
        repeat (2) @(negedge clock);
    endtask

    task automatic clear_cap();
        for (int i = 0; i < N; i++) begin
            cap_re[i] = 16'hdead;
            cap_im[i] = 16'hdead;
        end
    endtask

    task automatic check_ramp(input string tag);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_re[%0d]", tag, tbl[i].idx), longint'($signed(cap_re[tbl[i].idx])), tbl[i].re);
            chk($sformatf("%s_im[%0d]", tag, tbl[i].idx), longint'($signed(cap_im[tbl[i].idx])), tbl[i].im);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
        di_en = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clock);
        chk("rst_outputs", longint'({do_en, do_re, do_im, do_idx}), 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b1;
    endtask

    initial begin
        tbl[0] = '{idx: 0,  re: 0,  im: 0};
        tbl[1] = '{idx: 1,  re: 32, im: -32};
        tbl[2] = '{idx: 2,  re: 16, im: -16};
        tbl[3] = '{idx: 3,  re: 48, im: -48};
        tbl[4] = '{idx: 63, re: 63, im: -63};

        repeat (3) @(negedge clock);
        chk("rst_do_en", do_en, 0);
        chk("rst_data", longint'({do_re, do_im, do_idx}), 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single ramp frame, latency and run length.
        clear_cap();
        send(0, 1'b0, 1'b1, N);
        drain();
        chk("latency", first_rise, t_last + 2);
        chk("run_len", last_run, N);
        check_ramp("ramp");

        // Same ramp with one-cycle gaps.
        clear_cap();
        send(0, 1'b1, 1'b1, N);
        drain();
        chk("gap_latency", first_rise, t_last + 2);
        chk("gap_run_len", last_run, N);
        chk("gap_overflow", overflow, 0);
        check_ramp("gap");

        // Four frames back to back.
        for (int f = 0; f < 4; f++) send(256 * f, 1'b0, 1'b1, N);
        drain();
        chk("stream_run_len", last_run, 4 * N);
        chk("stream_overflow", overflow, 0);

        // Reset after 20 samples, then a clean frame.
        send(1000, 1'b0, 1'b0, 20);
        pulse_reset();
        repeat (10) @(negedge clock);
        clear_cap();
        send(0, 1'b0, 1'b1, N);
        drain();
        check_ramp("post_rst");

        // Reset in the middle of a read; nothing may follow.
        send(500, 1'b0, 1'b1, N);
        for (int i = 0; i < 200 && !do_en; i++) @(negedge clock);
        chk("midread_started", do_en, 1);
        repeat (10) @(negedge clock);
        pulse_reset();
        repeat (80) @(negedge clock);

        // Overflow: two frames, then one sample while the target bank is held busy.
        send(2000, 1'b0, 1'b1, N);
        send(3000, 1'b0, 1'b1, N);
        @(negedge clock);
        force dut.wr_block = 2'b11;
        di_en = 1'b1;
        di_re = 16'h7fff;
        di_im = 16'h8001;
        @(negedge clock);
        release dut.wr_block;
        di_en = 1'b0;
        drain();
        chk("ovf_run_len", last_run, 2 * N);
        chk("ovf_flag", overflow, 1);
        repeat (5) @(negedge clock);
        chk("ovf_sticky", overflow, 1);
        pulse_reset();
        chk("ovf_cleared", overflow, 0);
        repeat (4) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
